// File: rtl/vga_cell_scanout_pkg.sv
// Shared VGA 640x480@60 timing constants, cell-grid helpers and colour-field
// bit positions for the cell scanout block.
package vga_cell_scanout_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  // Colour byte layout: bits[7:6] unused, then R, G, B two bits each.
  localparam int RED_HI   = 5;
  localparam int RED_LO   = 4;
  localparam int GREEN_HI = 3;
  localparam int GREEN_LO = 2;
  localparam int BLUE_HI  = 1;
  localparam int BLUE_LO  = 0;

  function automatic int cell_cols(input int h_active, input int cell_w);
    return h_active / cell_w;
  endfunction

  function automatic int cell_rows(input int v_active, input int cell_h);
    return v_active / cell_h;
  endfunction

endpackage

// File: rtl/vga_timing_core.sv
// Pixel tick divider, horizontal/vertical position counters, raw sync levels
// and active-region flag.
module vga_timing_core
  import vga_cell_scanout_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PCLK_DIV = 2,
  parameter int HW       = 10,
  parameter int VW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  output logic          tick,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          h_wrap,
  output logic          v_wrap,
  output logic          active,
  output logic          hsync_raw,
  output logic          vsync_raw
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;

  logic [DW-1:0] div_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (div_cnt == DW'(PCLK_DIV - 1)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // Tick on count zero so the first clk after reset release is already a pixel.
  assign tick   = (div_cnt == '0);
  assign h_wrap = (hcount == HW'(H_TOTAL - 1));
  assign v_wrap = (vcount == VW'(V_TOTAL - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount <= '0;
      vcount <= '0;
    end else if (tick) begin
      if (h_wrap) begin
        hcount <= '0;
        vcount <= v_wrap ? '0 : vcount + VW'(1);
      end else begin
        hcount <= hcount + HW'(1);
      end
    end
  end

  assign active = (hcount < HW'(H_ACTIVE)) && (vcount < VW'(V_ACTIVE));

  assign hsync_raw = ((hcount >= HW'(H_ACTIVE + H_FP)) &&
                      (hcount <  HW'(H_ACTIVE + H_FP + H_SYNC))) ? HS_POL : ~HS_POL;
  assign vsync_raw = ((vcount >= VW'(V_ACTIVE + V_FP)) &&
                      (vcount <  VW'(V_ACTIVE + V_FP + V_SYNC))) ? VS_POL : ~VS_POL;

endmodule

// File: rtl/vga_cell_scanout.sv
// Cell-based VGA scanout: per-cell VRAM addressing, two-tick colour/sync
// pipeline and frame-synchronous double-buffer swap.
module vga_cell_scanout
  import vga_cell_scanout_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PCLK_DIV = 2,
  parameter int CELL_W   = 8,
  parameter int CELL_H   = 8,
  parameter int AW       = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          swap_req,
  output logic          swap_ack,
  output logic          buf_sel,
  output logic [AW-1:0] vram_addr,
  output logic          vram_rd_low,
  input  logic [7:0]    vram_data,
  output logic          hsync,
  output logic          vsync,
  output logic [1:0]    vga_red,
  output logic [1:0]    vga_green,
  output logic [1:0]    vga_blue,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam int COLS    = cell_cols(H_ACTIVE, CELL_W);
  localparam int XW      = (CELL_W > 1) ? $clog2(CELL_W) : 1;
  localparam int YW      = (CELL_H > 1) ? $clog2(CELL_H) : 1;

  logic          tick;
  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic          h_wrap;
  logic          v_wrap;
  logic          active;
  logic          hsync_raw;
  logic          vsync_raw;

  vga_timing_core #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .HS_POL   (HS_POL),   .VS_POL (VS_POL), .PCLK_DIV (PCLK_DIV),
    .HW       (HW),       .VW (VW)
  ) u_timing (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .hcount    (hcount),
    .vcount    (vcount),
    .h_wrap    (h_wrap),
    .v_wrap    (v_wrap),
    .active    (active),
    .hsync_raw (hsync_raw),
    .vsync_raw (vsync_raw)
  );

  logic          h_vis;
  logic          v_vis;
  logic [XW-1:0] px_in_cell;
  logic [YW-1:0] ln_in_cell;
  logic [AW-1:0] row_base;
  logic [AW-1:0] cell_addr;

  assign h_vis = (hcount < HW'(H_ACTIVE));
  assign v_vis = (vcount < VW'(V_ACTIVE));

  // cell_addr always holds the cell address of the current (hcount, vcount).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      px_in_cell <= '0;
      ln_in_cell <= '0;
      row_base   <= '0;
      cell_addr  <= '0;
    end else if (tick) begin
      if (h_wrap) begin
        px_in_cell <= '0;
        if (v_wrap) begin
          ln_in_cell <= '0;
          row_base   <= '0;
          cell_addr  <= '0;
        end else if (v_vis && (ln_in_cell == YW'(CELL_H - 1))) begin
          ln_in_cell <= '0;
          row_base   <= row_base + AW'(COLS);
          cell_addr  <= row_base + AW'(COLS);
        end else begin
          if (v_vis) ln_in_cell <= ln_in_cell + YW'(1);
          cell_addr <= row_base;
        end
      end else if (h_vis) begin
        if (px_in_cell == XW'(CELL_W - 1)) begin
          px_in_cell <= '0;
          cell_addr  <= cell_addr + AW'(1);
        end else begin
          px_in_cell <= px_in_cell + XW'(1);
        end
      end
    end
  end

  logic act_d;
  logic hs_d;
  logic vs_d;
  logic unused_hi_bits;

  assign unused_hi_bits = ^vram_data[7:6];

  // Stage 1 presents the address; stage 2 captures the returned byte with its syncs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vram_addr   <= '0;
      vram_rd_low <= 1'b1;
      act_d       <= 1'b0;
      hs_d        <= ~HS_POL;
      vs_d        <= ~VS_POL;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      vga_red     <= '0;
      vga_green   <= '0;
      vga_blue    <= '0;
    end else if (tick) begin
      vram_rd_low <= ~active;
      if (active) vram_addr <= cell_addr;
      act_d <= active;
      hs_d  <= hsync_raw;
      vs_d  <= vsync_raw;
      hsync <= hs_d;
      vsync <= vs_d;
      if (act_d) begin
        vga_red   <= vram_data[RED_HI:RED_LO];
        vga_green <= vram_data[GREEN_HI:GREEN_LO];
        vga_blue  <= vram_data[BLUE_HI:BLUE_LO];
      end else begin
        vga_red   <= '0;
        vga_green <= '0;
        vga_blue  <= '0;
      end
    end
  end

  logic swap_point;
  logic req_q;
  logic req_rise;
  logic armed;
  logic serve;

  assign swap_point = tick && (hcount == '0) && (vcount == VW'(V_ACTIVE));
  assign req_rise   = swap_req && !req_q;
  assign serve      = swap_point && swap_req && (armed || req_rise);

  // req_q resets high so a request still held across reset is not honoured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q       <= 1'b1;
      armed       <= 1'b0;
      buf_sel     <= 1'b0;
      swap_ack    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      req_q       <= swap_req;
      swap_ack    <= serve;
      frame_start <= tick && (hcount == '0) && (vcount == '0);
      if (serve) begin
        buf_sel <= ~buf_sel;
        armed   <= 1'b0;
      end else if (req_rise) begin
        armed <= 1'b1;
      end
    end
  end

endmodule
